uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that complements the existing uart_tx. It sits beside the transmitter behind the memory-mapped I/O decoder.
- Receives 8N1 frames on an asynchronous input pin.
- Buffers received bytes in a small show-ahead FIFO.
- Exposes a pop handshake and sticky error flags, so firmware can poll or drain bytes through a status/data register pair.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. DIV = CLK_FREQ/BAUD, integer floor; DIV >= 8 is required.
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- uart_rxd  input  1  asynchronous serial input; idle high.
- rd_en  input  1  pop the head byte when rx_valid=1; ignored when empty.
- rd_data  output  8  head byte of the FIFO, combinational show-ahead; 0 when empty.
- rx_valid  output  1  FIFO not empty.
- rx_count  output  $clog2(FIFO_DEPTH)+1  number of bytes stored.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- clr_err  input  1  clears frame_err and overrun.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: reset is active-low, synchronous to clk. While reset=0:
  - FSM goes to IDLE.
  - Synchronizer flops are set to 1.
  - FIFO pointers and count are set to 0.
  - rx_valid=0, rd_data=0, frame_err=0, overrun=0, busy=0.
  - A frame in progress is abandoned and its bits are discarded.
- Input path: uart_rxd passes through a 2-FF synchronizer into rxd_s. All decisions use rxd_s only.
- Baud counter: loads on state entry and counts down to 0. A sample is taken on the cycle the counter reaches 0.
- FSM states:
  - IDLE: a 1->0 transition on rxd_s moves to START with counter = DIV/2-1.
  - START: at the sample, if rxd_s=0, go to DATA (counter=DIV-1, bit index=0). If rxd_s=1 it was a glitch: return to IDLE with no flags set.
  - DATA: at each sample, shift rxd_s in LSB-first. After bit 7, go to STOP with counter=DIV-1.
  - STOP, sample = 1: push the byte and return to IDLE.
  - STOP, sample = 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE. A held-low line therefore produces exactly one frame_err and no spurious frames.
- Timing: each data bit is sampled at the centre of its bit time. The push happens at the stop-bit centre sample. rx_valid and rx_count update on the following clock edge.
- FIFO:
  - Circular buffer with read and write pointers that wrap at FIFO_DEPTH.
  - rx_count ranges from 0 to FIFO_DEPTH.
  - rd_data = mem[rd_ptr] when count > 0.
- FIFO boundary cases:
  - Pop when empty: no change.
  - Push when full, no pop: the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both take effect, count stays FIFO_DEPTH, no overrun.
  - Push and pop in the same cycle when count is 1..FIFO_DEPTH-1: count unchanged.
- Sticky flags: clr_err clears both flags on the next edge. If an error event occurs in the same cycle as clr_err, the set wins.
- No parity, no 2-stop-bit support, no auto-baud.

Test Plan:
(All scenarios use CLK_FREQ=1600000, BAUD=100000, so DIV=16; FIFO_DEPTH=4.)
1. Basic frame: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_valid=1 exactly 1 cycle after the stop-bit centre sample; rd_data=0xA5; rx_count=1; frame_err=0. Then rd_en for 1 cycle -> rx_valid=0, rx_count=0.
2. Glitch rejection: drive uart_rxd low for 4 cycles, then high -> FSM returns to IDLE, nothing pushed, no flags, busy deasserts.
3. Framing error / break: send 0x3C with the stop bit low, then hold the line low for 40 bit times -> frame_err=1 once; FIFO empty; no further frames. After the line returns high, send 0x55 -> received correctly. Then clr_err -> frame_err=0.
4. Overrun: send 0x01..0x05 with no reads -> rx_count=4, overrun=1. Pops return 0x01, 0x02, 0x03, 0x04 in order; 0x05 is lost.
5. Simultaneous push/pop at full: fill with 4 bytes, assert rd_en on the push cycle of the 5th byte 0x66 -> overrun=0, rx_count=4, final pop order ends with 0x66. Also verify pointer wrap-around over 3 fill/drain cycles.
6. Reset mid-frame: assert reset during DATA bit 4 of 0xF0 -> all outputs zero, FIFO empty. After release, the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a show-ahead receive FIFO and sticky error flags.
// The line is synchronised, then sampled at the centre of each bit by a down-counter.
module uart_rx #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [NW-1:0] CNT_MAX  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic          sync_r;
  logic          rxd_s;
  logic          rxd_d_r;
  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [2:0]    bit_r, bit_n;
  logic [7:0]    shift_r, shift_n;
  logic          push_s, ferr_s, sample_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [NW-1:0] count_r;
  logic          do_pop_s, do_push_s, full_s, ovr_s;
  logic          frame_err_r, overrun_r;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r  <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_d_r <= 1'b1;
    end else begin
      sync_r  <= uart_rxd;
      rxd_s   <= sync_r;
      rxd_d_r <= rxd_s;
    end
  end

  // Receive FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
    end
  end

  // Next-state logic; a sample is taken on the cycle the counter sits at zero.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    bit_n    = bit_r;
    shift_n  = shift_r;
    push_s   = 1'b0;
    ferr_s   = 1'b0;
    sample_s = (cnt_r == {CW{1'b0}});
    case (state_r)
      IDLE: begin
        if (rxd_d_r && !rxd_s) begin
          state_n = START;
          cnt_n   = CNT_HALF;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (!sample_s) begin
          cnt_n = cnt_r - 1'b1;
        end else if (!rxd_s) begin
          state_n = DATA;
          cnt_n   = CNT_FULL;
          bit_n   = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!sample_s) begin
          cnt_n = cnt_r - 1'b1;
        end else begin
          shift_n = {rxd_s, shift_r[7:1]};
          cnt_n   = CNT_FULL;
          if (bit_r == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_r + 3'd1;
          end
        end
      end
      STOP: begin
        if (!sample_s) begin
          cnt_n = cnt_r - 1'b1;
        end else if (rxd_s) begin
          push_s  = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_s  = 1'b1;
          state_n = BRK;
        end
      end
      BRK: begin
        if (rxd_s) begin
          state_n = IDLE;
        end else begin
          state_n = BRK;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A push into a full FIFO only succeeds if a pop frees a slot in the same cycle.
  assign full_s    = (count_r == CNT_MAX);
  assign do_pop_s  = rd_en && (count_r != {NW{1'b0}});
  assign do_push_s = push_s && (!full_s || do_pop_s);
  assign ovr_s     = push_s && full_s && !do_pop_s;

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {NW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (reset && do_push_s) mem[wr_ptr_r] <= shift_r;
  end

  // Sticky error flags; a new error event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (ferr_s)       frame_err_r <= 1'b1;
      else if (clr_err) frame_err_r <= 1'b0;
      if (ovr_s)        overrun_r   <= 1'b1;
      else if (clr_err) overrun_r   <= 1'b0;
    end
  end

  assign rd_data   = (count_r != {NW{1'b0}}) ? mem[rd_ptr_r] : 8'h00;
  assign rx_valid  = (count_r != {NW{1'b0}});
  assign rx_count  = count_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, a queue model of the FIFO
// holds the expected bytes and a monitor compares every pop against it.
module tb_uart_rx;

  localparam int CLK_FREQ   = 1600000;
  localparam int BAUD       = 100000;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = CLK_FREQ / BAUD;
  // 2 synchroniser flops + 1 edge-detect cycle + half a bit + 9 full bits to the stop centre.
  localparam int PUSH_EDGE  = 2 + 1 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_q[$];
  logic       exp_ovr = 1'b0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rd_en(rd_en),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must return the head of the model queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset && rd_en && rx_valid) begin
        if (model_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got %0h expected no data", rd_data);
        end else begin
          e = model_q.pop_front();
          chk("pop_data", {24'h0, rd_data}, {24'h0, e});
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_at_push,
                            input bit chk_timing);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10 * DIV; k++) begin
      uart_rxd = fr[k / DIV];
      rd_en    = pop_at_push && (k == PUSH_EDGE - 1);
      @(posedge clk); #1;
      if (chk_timing && k == PUSH_EDGE - 2) chk("valid_before_push", rx_valid, 0);
      if (chk_timing && k == PUSH_EDGE - 1) chk("valid_at_push", rx_valid, 1);
    end
    rd_en = 1'b0;
    if (stop_ok) begin
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_one();
    @(posedge clk); #1;
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (rx_valid && guard < 2 * FIFO_DEPTH + 2) begin
      pop_one();
      guard++;
    end
    chk("drain_empty", rx_valid, 0);
    chk("drain_model_empty", model_q.size(), 0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  // Watchdog keeps the run bounded even if the DUT wedges.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] rb;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    // Basic frame with push timing.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("basic_data", rd_data, 8'hA5);
    chk("basic_count", rx_count, 1);
    chk("basic_ferr", frame_err, 0);
    pop_one();
    chk("basic_valid_after_pop", rx_valid, 0);
    chk("basic_count_after_pop", rx_count, 0);

    // Glitch rejection.
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    chk("glitch_busy", busy, 1);
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovr", overrun, 0);

    // Framing error followed by a held-low break.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (20 * DIV) @(posedge clk);
    #1;
    chk("break_ferr", frame_err, 1);
    chk("break_valid", rx_valid, 0);
    chk("break_busy", busy, 1);
    pulse_clr();
    repeat (20 * DIV) @(posedge clk);
    #1;
    chk("break_no_refire", frame_err, 0);
    chk("break_no_frame", rx_valid, 0);
    uart_rxd = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("break_exit", busy, 0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    chk("after_break_data", rd_data, 8'h55);
    drain();

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovr_count", rx_count, FIFO_DEPTH);
    chk("ovr_flag", overrun, exp_ovr);
    chk("ovr_model", exp_ovr, 1);
    drain();
    pulse_clr();
    exp_ovr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Push and pop together at full, repeated so the pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      send_frame(8'h66, 1'b1, 1'b1, 1'b0);
      chk("simul_ovr", overrun, 0);
      chk("simul_count", rx_count, FIFO_DEPTH);
      chk("simul_tail", model_q[FIFO_DEPTH-1], 8'h66);
      drain();
    end

    // Reset in the middle of a frame, with a byte already buffered.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    fr = {1'b1, 8'hF0, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 5 * DIV + DIV / 2; k++) begin
      uart_rxd = fr[k / DIV];
      @(posedge clk); #1;
    end
    chk("midframe_busy", busy, 1);
    reset = 1'b0;
    uart_rxd = 1'b1;
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rd_data, 0);
    chk("mid_rst_count", rx_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flags", {frame_err, overrun}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", rd_data, 8'h81);
    drain();

    // Random traffic with random drain points.
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0, 1'b0);
      chk("rand_count", rx_count, model_q.size());
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    chk("rand_ovr", overrun, exp_ovr);
    chk("final_ferr", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
